apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
- Two-master to one-slave APB arbiter in ctrl_sys, between the requesters and top_regfile.
- Master 0 is the mdio_top request port; master 1 is a second on-chip requester (debug/capture sequencer).
- Round-robin arbitration, registered slave-side sequencing and an access timeout that returns a slave error, so a stalled regfile never hangs MDIO.

Parameters:
- ADDR_W, 21, APB address width
- DATA_W, 16, APB data width
- TMO_W, 8, timeout counter width; timeout fires after 2**TMO_W-1 ACCESS cycles without s_pready

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- m0_psel, m0_penable, m0_pwrite  in  1 each  master 0 APB control
- m0_paddr  in  ADDR_W  master 0 address
- m0_pwdata  in  DATA_W  master 0 write data
- m0_pready  out  1  master 0 completion
- m0_prdata  out  DATA_W  master 0 read data
- m0_pslverr  out  1  master 0 error
- m1_*  same set as m0_*  master 1
- s_psel, s_penable, s_pwrite  out  1 each  to top_regfile
- s_paddr  out  ADDR_W
- s_pwdata  out  DATA_W
- s_pready  in  1
- s_prdata  in  DATA_W
- s_pslverr  in  1
- busy  out  1  FSM not IDLE
- grant  out  1  index of master currently owning the slave
- tmo_cnt  out  8  saturating count of timeouts

Behaviour:
- Reset state: clk/rstn as above; reset is asynchronous and active-low. All outputs are 0; FSM is IDLE; last_grant=1, so master 0 wins the first tie.
- All outputs are registered.
- Request: mN_psel=1. A master must hold psel, paddr, pwrite and pwdata until it sees mN_pready.
- FSM states:
  - IDLE: if any request, pick the winner.
    - Both requesting: winner = !last_grant.
    - Otherwise the single requester wins.
    - Latch winner's paddr/pwrite/pwdata into s_*; set grant and last_grant to the winner; s_psel=1; go to SETUP.
  - SETUP: s_psel=1, s_penable=0, lasting one cycle. Set s_penable=1, clear the timeout counter, go to ACCESS.
  - ACCESS: s_psel=1, s_penable=1.
    - On s_pready=1: capture s_prdata and s_pslverr; drop s_psel and s_penable; go to DONE.
    - Else if counter==2**TMO_W-1: capture prdata=0 and pslverr=1; drop s_psel and s_penable; increment tmo_cnt, saturating at 255; go to DONE.
    - Else increment the counter.
  - DONE: pulse m[grant]_pready=1 for exactly one cycle, with the captured prdata/pslverr on that master's prdata/pslverr. The other master's outputs stay 0. Go to IDLE.
- Non-granted mN_pready, mN_prdata and mN_pslverr are always 0. Read data is 0 whenever pready is 0.
- Latency with a zero-wait slave: request sampled at cycle T; s_psel at T+1; s_penable at T+2; s_pready at T+2; mN_pready at T+3. Back-to-back throughput is one transfer per 4 cycles.
- A request arriving during a transfer waits. The losing master is always served next if it is still requesting (no starvation).
- Master drops psel mid-transfer (protocol violation): the slave transfer completes anyway and the pready pulse is still issued. The next IDLE sees no request.
- s_pready in SETUP is ignored. s_pslverr is only sampled together with s_pready.
- s_paddr, s_pwrite and s_pwdata are stable from SETUP through ACCESS and hold their last value afterwards.
- rstn assertion mid-transfer: immediate return to the reset state; no pready is issued.

Decomposition:
- Shared package ctrl_sys_pkg holds:
  - the FSM state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, DONE=2'd3);
  - the ADDR_W and DATA_W defaults;
  - TMO_W.
- One sub-module, apb_rr_pick: combinational 2-way round-robin winner from {m1_psel, m0_psel, last_grant}.

Test Plan:
- m0 reads 0x00010 with s_pready tied 1 and s_prdata=0xA5A5 -> s_psel at T+1, s_penable at T+2, m0_pready pulse at T+3 with m0_prdata=0xA5A5, m0_pslverr=0; m1 outputs stay 0.
- m0 and m1 request simultaneously from reset (m1 writes 0x1234 to 0x00002) -> m0 served first, then m1. s_pwdata=0x1234 and s_pwrite=1 are held stable through SETUP and ACCESS of m1's transfer.
- Both masters request continuously for 6 transfers -> grant alternates 0,1,0,1,0,1.
- Slave holds s_pready=0 -> after 255 ACCESS cycles, m0_pready=1, m0_pslverr=1, m0_prdata=0 and tmo_cnt=1. The next transfer proceeds normally.
- Slave inserts 3 wait states and returns s_pslverr=1 -> pready 3 cycles later than the zero-wait case, with pslverr=1 forwarded.
- rstn pulsed low during ACCESS -> all outputs 0 asynchronously; no pready issued. After release, a pending m1 request is granted, since master 0 is idle.

Source files
------------

// File: rtl/ctrl_sys_pkg.sv
// Shared ctrl_sys definitions: arbiter FSM encoding, default bus widths,
// timeout width and small arithmetic helpers.
package ctrl_sys_pkg;

    localparam int ADDR_W_DEF = 21;
    localparam int DATA_W_DEF = 16;
    localparam int TMO_W_DEF  = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_e;

    // Saturating 8-bit increment used for the timeout event counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// APB signal bundle for the two-master arbiter: both requester ports plus
// the single slave-side port toward top_regfile.
interface apb_req_arbiter_if
    import ctrl_sys_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              m0_psel, m0_penable, m0_pwrite;
    logic [ADDR_W-1:0] m0_paddr;
    logic [DATA_W-1:0] m0_pwdata;
    logic              m0_pready;
    logic [DATA_W-1:0] m0_prdata;
    logic              m0_pslverr;

    logic              m1_psel, m1_penable, m1_pwrite;
    logic [ADDR_W-1:0] m1_paddr;
    logic [DATA_W-1:0] m1_pwdata;
    logic              m1_pready;
    logic [DATA_W-1:0] m1_prdata;
    logic              m1_pslverr;

    logic              s_psel, s_penable, s_pwrite;
    logic [ADDR_W-1:0] s_paddr;
    logic [DATA_W-1:0] s_pwdata;
    logic              s_pready;
    logic [DATA_W-1:0] s_prdata;
    logic              s_pslverr;

    // Arbiter view: serves the requesters, drives the regfile.
    modport slave (
        input  m0_psel, m0_penable, m0_pwrite, m0_paddr, m0_pwdata,
        output m0_pready, m0_prdata, m0_pslverr,
        input  m1_psel, m1_penable, m1_pwrite, m1_paddr, m1_pwdata,
        output m1_pready, m1_prdata, m1_pslverr,
        output s_psel, s_penable, s_pwrite, s_paddr, s_pwdata,
        input  s_pready, s_prdata, s_pslverr
    );

    // Environment view: requesters and regfile around the arbiter.
    modport master (
        output m0_psel, m0_penable, m0_pwrite, m0_paddr, m0_pwdata,
        input  m0_pready, m0_prdata, m0_pslverr,
        output m1_psel, m1_penable, m1_pwrite, m1_paddr, m1_pwdata,
        input  m1_pready, m1_prdata, m1_pslverr,
        input  s_psel, s_penable, s_pwrite, s_paddr, s_pwdata,
        output s_pready, s_prdata, s_pslverr
    );

endinterface

// File: rtl/apb_rr_pick.sv
// Two-way round-robin winner: a lone requester wins, a tie goes to the
// master that did not win last time.
module apb_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic any_req,
    output logic winner
);

    assign any_req = req0 | req1;
    assign winner  = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/apb_req_arbiter.sv
// Two-master APB arbiter in front of top_regfile with registered slave
// sequencing and an ACCESS timeout that answers with a slave error.
module apb_req_arbiter
    import ctrl_sys_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TMO_W  = TMO_W_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    apb_req_arbiter_if.slave     bus,
    output logic                 busy,
    output logic                 grant,
    output logic [7:0]           tmo_cnt
);

    localparam logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}};
    localparam logic [TMO_W-1:0] CNT_ONE = {{(TMO_W-1){1'b0}}, 1'b1};

    arb_state_e        state_r, state_s;
    logic              s_psel_r, s_psel_s, s_penable_r, s_penable_s;
    logic              s_pwrite_r, s_pwrite_s;
    logic [ADDR_W-1:0] s_paddr_r, s_paddr_s;
    logic [DATA_W-1:0] s_pwdata_r, s_pwdata_s;
    logic              grant_r, grant_s, last_grant_r, last_grant_s;
    logic [TMO_W-1:0]  wait_cnt_r, wait_cnt_s;
    logic [7:0]        tmo_cnt_r, tmo_cnt_s;
    logic              busy_r, busy_s;
    logic              m0_pready_r, m0_pready_s, m0_pslverr_r, m0_pslverr_s;
    logic              m1_pready_r, m1_pready_s, m1_pslverr_r, m1_pslverr_s;
    logic [DATA_W-1:0] m0_prdata_r, m0_prdata_s, m1_prdata_r, m1_prdata_s;
    logic              done_s, done_err_s;
    logic [DATA_W-1:0] done_data_s;
    logic              pick_any_s, pick_win_s;
    logic              unused_penable_s;

    // penable carries no information for arbitration; a request is psel alone.
    assign unused_penable_s = bus.m0_penable ^ bus.m1_penable;

    apb_rr_pick u_pick (
        .req0       (bus.m0_psel),
        .req1       (bus.m1_psel),
        .last_grant (last_grant_r),
        .any_req    (pick_any_s),
        .winner     (pick_win_s)
    );

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_s      = state_r;
        s_psel_s     = s_psel_r;
        s_penable_s  = s_penable_r;
        s_pwrite_s   = s_pwrite_r;
        s_paddr_s    = s_paddr_r;
        s_pwdata_s   = s_pwdata_r;
        grant_s      = grant_r;
        last_grant_s = last_grant_r;
        wait_cnt_s   = wait_cnt_r;
        tmo_cnt_s    = tmo_cnt_r;
        m0_pready_s  = 1'b0;
        m0_prdata_s  = '0;
        m0_pslverr_s = 1'b0;
        m1_pready_s  = 1'b0;
        m1_prdata_s  = '0;
        m1_pslverr_s = 1'b0;
        done_s       = 1'b0;
        done_data_s  = '0;
        done_err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_any_s) begin
                    grant_s      = pick_win_s;
                    last_grant_s = pick_win_s;
                    s_psel_s     = 1'b1;
                    state_s      = ST_SETUP;
                    if (pick_win_s) begin
                        s_paddr_s  = bus.m1_paddr;
                        s_pwrite_s = bus.m1_pwrite;
                        s_pwdata_s = bus.m1_pwdata;
                    end else begin
                        s_paddr_s  = bus.m0_paddr;
                        s_pwrite_s = bus.m0_pwrite;
                        s_pwdata_s = bus.m0_pwdata;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                s_penable_s = 1'b1;
                wait_cnt_s  = '0;
                state_s     = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (bus.s_pready) begin
                    done_s      = 1'b1;
                    done_data_s = bus.s_prdata;
                    done_err_s  = bus.s_pslverr;
                    s_psel_s    = 1'b0;
                    s_penable_s = 1'b0;
                    state_s     = ST_DONE;
                end else if (wait_cnt_r == TMO_MAX) begin
                    done_s      = 1'b1;
                    done_data_s = '0;
                    done_err_s  = 1'b1;
                    s_psel_s    = 1'b0;
                    s_penable_s = 1'b0;
                    tmo_cnt_s   = sat_inc8(tmo_cnt_r);
                    state_s     = ST_DONE;
                end else begin
                    wait_cnt_s = wait_cnt_r + CNT_ONE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                s_psel_s    = 1'b0;
                s_penable_s = 1'b0;
                state_s     = ST_IDLE;
            end
        endcase
        // Completion is routed only to the owner; the other master sees zeros.
        if (done_s) begin
            if (grant_r) begin
                m1_pready_s  = 1'b1;
                m1_prdata_s  = done_data_s;
                m1_pslverr_s = done_err_s;
            end else begin
                m0_pready_s  = 1'b1;
                m0_prdata_s  = done_data_s;
                m0_pslverr_s = done_err_s;
            end
        end else begin
            m0_pready_s = 1'b0;
            m1_pready_s = 1'b0;
        end
        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= ST_IDLE;
            s_psel_r     <= 1'b0;
            s_penable_r  <= 1'b0;
            s_pwrite_r   <= 1'b0;
            s_paddr_r    <= '0;
            s_pwdata_r   <= '0;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            wait_cnt_r   <= '0;
            tmo_cnt_r    <= 8'd0;
            busy_r       <= 1'b0;
            m0_pready_r  <= 1'b0;
            m0_prdata_r  <= '0;
            m0_pslverr_r <= 1'b0;
            m1_pready_r  <= 1'b0;
            m1_prdata_r  <= '0;
            m1_pslverr_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            s_psel_r     <= s_psel_s;
            s_penable_r  <= s_penable_s;
            s_pwrite_r   <= s_pwrite_s;
            s_paddr_r    <= s_paddr_s;
            s_pwdata_r   <= s_pwdata_s;
            grant_r      <= grant_s;
            last_grant_r <= last_grant_s;
            wait_cnt_r   <= wait_cnt_s;
            tmo_cnt_r    <= tmo_cnt_s;
            busy_r       <= busy_s;
            m0_pready_r  <= m0_pready_s;
            m0_prdata_r  <= m0_prdata_s;
            m0_pslverr_r <= m0_pslverr_s;
            m1_pready_r  <= m1_pready_s;
            m1_prdata_r  <= m1_prdata_s;
            m1_pslverr_r <= m1_pslverr_s;
        end
    end

    assign bus.s_psel     = s_psel_r;
    assign bus.s_penable  = s_penable_r;
    assign bus.s_pwrite   = s_pwrite_r;
    assign bus.s_paddr    = s_paddr_r;
    assign bus.s_pwdata   = s_pwdata_r;
    assign bus.m0_pready  = m0_pready_r;
    assign bus.m0_prdata  = m0_prdata_r;
    assign bus.m0_pslverr = m0_pslverr_r;
    assign bus.m1_pready  = m1_pready_r;
    assign bus.m1_prdata  = m1_prdata_r;
    assign bus.m1_pslverr = m1_pslverr_r;
    assign busy           = busy_r;
    assign grant          = grant_r;
    assign tmo_cnt        = tmo_cnt_r;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: directed vector table plus
// hand-written tie, alternation and mid-transfer reset sequences.
module tb_apb_req_arbiter;
    import ctrl_sys_pkg::*;

    localparam int AW = 21;
    localparam int DW = 16;

    typedef struct {
        logic          m;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          err;
        logic          tie;
        logic          stk;
        int            waits;
        int            exp_lat;
        logic [DW-1:0] exp_rdata;
        logic          exp_err;
        logic [7:0]    exp_tmo;
    } vec_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       busy, grant;
    logic [7:0] tmo_cnt;
    int         n_cmp = 0;
    int         n_bad = 0;
    bit         tie_ready = 1'b0;
    bit         stuck = 1'b0;
    int         waits = 0;
    int         wcnt = 0;
    vec_t       vecs[6];

    always #5 clk = ~clk;

    apb_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TMO_W(8)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .bus     (bus),
        .busy    (busy),
        .grant   (grant),
        .tmo_cnt (tmo_cnt)
    );

    // Slave model: tied-ready, N wait states, or never ready.
    always @(negedge clk) begin
        if (tie_ready) begin
            bus.s_pready = 1'b1;
        end else if (bus.s_psel && bus.s_penable && !stuck) begin
            bus.s_pready = (wcnt == waits);
            wcnt++;
        end else begin
            bus.s_pready = 1'b0;
            wcnt = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic pready_of(input logic m);
        return m ? bus.m1_pready : bus.m0_pready;
    endfunction

    function automatic logic [DW-1:0] prdata_of(input logic m);
        return m ? bus.m1_prdata : bus.m0_prdata;
    endfunction

    function automatic logic pslverr_of(input logic m);
        return m ? bus.m1_pslverr : bus.m0_pslverr;
    endfunction

    task automatic drive_m(input logic m, input logic sel, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (m) begin
            bus.m1_psel = sel; bus.m1_pwrite = wr; bus.m1_paddr = a; bus.m1_pwdata = d;
        end else begin
            bus.m0_psel = sel; bus.m0_pwrite = wr; bus.m0_paddr = a; bus.m0_pwdata = d;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},    32'(busy), 32'd0);
        chk({tag, "_grant"},   32'(grant), 32'd0);
        chk({tag, "_tmo"},     32'(tmo_cnt), 32'd0);
        chk({tag, "_spsel"},   32'({bus.s_psel, bus.s_penable, bus.s_pwrite}), 32'd0);
        chk({tag, "_spaddr"},  32'(bus.s_paddr), 32'd0);
        chk({tag, "_spwdata"}, 32'(bus.s_pwdata), 32'd0);
        chk({tag, "_m0"},      32'({bus.m0_pready, bus.m0_pslverr, bus.m0_prdata}), 32'd0);
        chk({tag, "_m1"},      32'({bus.m1_pready, bus.m1_pslverr, bus.m1_prdata}), 32'd0);
    endtask

    // One isolated transfer from IDLE; caller is at a negedge with the FSM idle.
    task automatic run_one(input int idx, input vec_t v);
        int lat;
        string p;
        lat = 0;
        p = $sformatf("v%0d", idx);
        tie_ready = v.tie; stuck = v.stk; waits = v.waits;
        bus.s_prdata = v.rdata; bus.s_pslverr = v.err;
        drive_m(v.m, 1'b1, v.wr, v.addr, v.wdata);
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk({p, "_setup_psel"}, 32'({bus.s_psel, bus.s_penable}), 32'h2);
                chk({p, "_setup_addr"}, 32'(bus.s_paddr), 32'(v.addr));
                chk({p, "_setup_wr"},   32'(bus.s_pwrite), 32'(v.wr));
                chk({p, "_setup_wd"},   32'(bus.s_pwdata), 32'(v.wdata));
                chk({p, "_busy"},       32'(busy), 32'd1);
            end
            if (i == 2) begin
                chk({p, "_access"},     32'({bus.s_psel, bus.s_penable}), 32'h3);
                chk({p, "_access_addr"}, 32'(bus.s_paddr), 32'(v.addr));
            end
            if (pready_of(v.m)) begin
                lat = i;
                break;
            end
        end
        chk({p, "_latency"}, 32'(lat), 32'(v.exp_lat));
        chk({p, "_prdata"},  32'(prdata_of(v.m)), 32'(v.exp_rdata));
        chk({p, "_pslverr"}, 32'(pslverr_of(v.m)), 32'(v.exp_err));
        chk({p, "_other"},   32'({pready_of(!v.m), pslverr_of(!v.m), prdata_of(!v.m)}), 32'd0);
        chk({p, "_grant"},   32'(grant), 32'(v.m));
        chk({p, "_tmo"},     32'(tmo_cnt), 32'(v.exp_tmo));
        drive_m(v.m, 1'b0, v.wr, v.addr, v.wdata);
        @(negedge clk);
        chk({p, "_pulse_end"}, 32'({pready_of(v.m), prdata_of(v.m)}), 32'd0);
        chk({p, "_idle"},      32'(busy), 32'd0);
    endtask

    initial begin
        int  lat, k, last_t;
        bit  seen0, seen1;
        logic [0:5] exp_seq;

        vecs[0] = '{1'b0, 1'b0, 21'h00010,  16'h0000, 16'hA5A5, 1'b0, 1'b1, 1'b0, 0, 3,   16'hA5A5, 1'b0, 8'd0};
        vecs[1] = '{1'b1, 1'b1, 21'h00002,  16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 3,   16'h0000, 1'b0, 8'd0};
        vecs[2] = '{1'b0, 1'b0, 21'h1FFFFF, 16'h0F0F, 16'h00C3, 1'b1, 1'b0, 1'b0, 3, 6,   16'h00C3, 1'b1, 8'd0};
        vecs[3] = '{1'b1, 1'b0, 21'h0ABCD,  16'h0000, 16'h8001, 1'b0, 1'b0, 1'b0, 1, 4,   16'h8001, 1'b0, 8'd0};
        vecs[4] = '{1'b0, 1'b0, 21'h00040,  16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b1, 0, 258, 16'h0000, 1'b1, 8'd1};
        vecs[5] = '{1'b0, 1'b1, 21'h00044,  16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b0, 0, 3,   16'h0000, 1'b0, 8'd1};

        rstn = 1'b0;
        drive_m(1'b0, 1'b0, 1'b0, '0, '0);
        drive_m(1'b1, 1'b0, 1'b0, '0, '0);
        bus.m0_penable = 1'b0; bus.m1_penable = 1'b0;
        bus.s_pready = 1'b0; bus.s_prdata = '0; bus.s_pslverr = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("rst_held");
        rstn = 1'b1;
        @(negedge clk);
        chk_zero("rst_released");

        // Simultaneous request from reset: m0 first, then m1 write held stable.
        tie_ready = 1'b0; stuck = 1'b0; waits = 0;
        bus.s_prdata = 16'h1111; bus.s_pslverr = 1'b0;
        drive_m(1'b0, 1'b1, 1'b0, 21'h00010, 16'h0000);
        drive_m(1'b1, 1'b1, 1'b1, 21'h00002, 16'h1234);
        seen0 = 1'b0; seen1 = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) chk("tie_first_grant", 32'(grant), 32'd0);
            if (seen0 && bus.s_psel) begin
                chk("tie_m1_pwdata", 32'(bus.s_pwdata), 32'h1234);
                chk("tie_m1_pwrite", 32'(bus.s_pwrite), 32'd1);
                chk("tie_m1_paddr",  32'(bus.s_paddr), 32'h2);
            end
            if (bus.m0_pready) begin
                seen0 = 1'b1;
                chk("tie_m0_lat",    32'(i), 32'd3);
                chk("tie_m0_prdata", 32'(bus.m0_prdata), 32'h1111);
                chk("tie_m1_quiet",  32'(bus.m1_pready), 32'd0);
                bus.m0_psel = 1'b0;
                bus.s_prdata = 16'h0000;
            end
            if (bus.m1_pready) begin
                seen1 = 1'b1;
                chk("tie_m1_lat",   32'(i), 32'd7);
                chk("tie_m1_grant", 32'(grant), 32'd1);
                bus.m1_psel = 1'b0;
                break;
            end
        end
        chk("tie_both_served", 32'({seen0, seen1}), 32'h3);
        bus.m0_psel = 1'b0; bus.m1_psel = 1'b0;
        @(negedge clk);

        // Continuous requests from both: grants alternate, one transfer per 4 cycles.
        exp_seq = 6'b010101;
        k = 0; last_t = 0;
        drive_m(1'b0, 1'b1, 1'b0, 21'h00100, 16'h0000);
        drive_m(1'b1, 1'b1, 1'b0, 21'h00200, 16'h0000);
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (bus.m0_pready || bus.m1_pready) begin
                chk($sformatf("alt%0d_both", k), 32'(bus.m0_pready & bus.m1_pready), 32'd0);
                chk($sformatf("alt%0d_who", k),  32'(bus.m1_pready), 32'(exp_seq[k]));
                chk($sformatf("alt%0d_grant", k), 32'(grant), 32'(exp_seq[k]));
                if (k > 0) chk($sformatf("alt%0d_gap", k), 32'(i - last_t), 32'd4);
                last_t = i;
                k++;
                if (k == 6) break;
            end
        end
        chk("alt_count", 32'(k), 32'd6);
        bus.m0_psel = 1'b0; bus.m1_psel = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) run_one(v, vecs[v]);

        // Reset during ACCESS with m1 pending; m1 is granted after release.
        tie_ready = 1'b0; stuck = 1'b1; waits = 0;
        bus.s_prdata = 16'h7E57; bus.s_pslverr = 1'b0;
        drive_m(1'b0, 1'b1, 1'b0, 21'h00300, 16'h0000);
        repeat (4) @(negedge clk);
        chk("rst_pre_access", 32'({bus.s_psel, bus.s_penable}), 32'h3);
        drive_m(1'b1, 1'b1, 1'b0, 21'h00321, 16'h0000);
        rstn = 1'b0;
        #1;
        chk_zero("rst_async");
        bus.m0_psel = 1'b0;
        stuck = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_pready", 32'({bus.m0_pready, bus.m1_pready}), 32'd0);
        end
        rstn = 1'b1;
        lat = 0; seen0 = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.m0_pready) seen0 = 1'b1;
            if (bus.m1_pready) begin
                lat = i;
                break;
            end
        end
        chk("post_rst_m1_lat",    32'(lat), 32'd3);
        chk("post_rst_grant",     32'(grant), 32'd1);
        chk("post_rst_m1_prdata", 32'(bus.m1_prdata), 32'h7E57);
        chk("post_rst_m0_quiet",  32'(seen0), 32'd0);
        chk("post_rst_tmo",       32'(tmo_cnt), 32'd0);
        bus.m1_psel = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
